// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FIFO operation encoding and width helpers for the UART receive buffer
package uart_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   // {push, pop} as seen by the storage block on one edge
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // one extra bit so that a completely full buffer (count == DEPTH) is representable
   function automatic int cnt_w(input int depth);
      return ptr_w(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// rtl/uart_rx_buffer_if.sv - receiver-side push/pop/status bundle of the UART receive buffer
interface uart_rx_buffer_if
   import uart_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
);

   logic                      rx_ready;
   logic [DATA_W-1:0]         data;
   logic                      read;
   logic                      clr_err;
   logic [DATA_W-1:0]         data_out;
   logic                      out_valid;
   logic                      empty;
   logic                      full;
   logic                      almost_full;
   logic [cnt_w(DEPTH)-1:0]   count;
   logic                      overflow;
   logic                      underflow;

   modport master (
      output rx_ready, data, read, clr_err,
      input  data_out, out_valid, empty, full, almost_full, count, overflow, underflow
   );

   modport slave (
      input  rx_ready, data, read, clr_err,
      output data_out, out_valid, empty, full, almost_full, count, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - circular word storage with read/write pointers and registered occupancy flags
module sync_fifo_mem
   import uart_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int PTR_W  = ptr_w(DEPTH),
   localparam int CNT_W  = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              r_full;
   logic              r_empty;
   fifo_op_e          w_op;

   assign w_op = fifo_op_e'({push, pop});

   always_comb begin
      w_count_nxt = r_count;
      case (w_op)
         OP_PUSH: w_count_nxt = r_count + CNT_W'(1);
         OP_POP:  w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // storage is left untouched by reset; only the pointers define what is held
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the wrap from DEPTH-1 to 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign rdata = r_mem[r_rptr];
   assign count = r_count;
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive buffer: edge-qualified push/pop, registered output word, sticky error flags
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int RD_EDGE  = 1
) (
   input logic             clk,
   input logic             rst,
   uart_rx_buffer_if.slave bus
);

   localparam int               CNT_W      = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT     = CNT_W'(AF_LEVEL);
   localparam logic             RD_IS_EDGE = (RD_EDGE != 0);

   logic              r_rx_prev;
   logic              r_rd_prev;
   logic [DATA_W-1:0] r_data_out;
   logic              r_out_valid;
   logic              r_overflow;
   logic              r_underflow;
   logic              r_almost_full;

   logic [DATA_W-1:0] w_rdata;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              w_full;
   logic              w_empty;
   logic              w_push_req;
   logic              w_pop_req;
   logic              w_push_acc;
   logic              w_pop_acc;
   logic              w_ovf_evt;
   logic              w_unf_evt;
   fifo_op_e          w_op;

   assign w_push_req = bus.rx_ready & ~r_rx_prev;
   assign w_pop_req  = bus.read & (~RD_IS_EDGE | ~r_rd_prev);

   // a pop on a full buffer frees the slot the simultaneous push lands in; no empty bypass
   assign w_pop_acc  = w_pop_req & ~w_empty;
   assign w_push_acc = w_push_req & (~w_full | w_pop_acc);
   assign w_ovf_evt  = w_push_req & w_full & ~w_pop_req;
   assign w_unf_evt  = w_pop_req & w_empty;
   assign w_op       = fifo_op_e'({w_push_acc, w_pop_acc});

   always_comb begin
      w_count_nxt = w_count;
      case (w_op)
         OP_PUSH: w_count_nxt = w_count + CNT_W'(1);
         OP_POP:  w_count_nxt = w_count - CNT_W'(1);
         default: w_count_nxt = w_count;
      endcase
   end

   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push_acc),
      .pop   (w_pop_acc),
      .wdata (bus.data),
      .rdata (w_rdata),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   // history resets high so a level already asserted when reset releases is not an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_prev <= 1'b1;
         r_rd_prev <= 1'b1;
      end else begin
         r_rx_prev <= bus.rx_ready;
         r_rd_prev <= bus.read;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out    <= '0;
         r_out_valid   <= 1'b0;
         r_almost_full <= 1'b0;
      end else begin
         r_out_valid   <= w_pop_acc;
         r_almost_full <= (w_count_nxt >= AF_CNT);
         if (w_pop_acc) begin
            r_data_out <= w_rdata;
         end
      end
   end

   // a fresh error outranks a clear arriving on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_evt) begin
            r_overflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_overflow <= 1'b0;
         end
         if (w_unf_evt) begin
            r_underflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign bus.data_out    = r_data_out;
   assign bus.out_valid   = r_out_valid;
   assign bus.empty       = w_empty;
   assign bus.full        = w_full;
   assign bus.almost_full = r_almost_full;
   assign bus.count       = w_count;
   assign bus.overflow    = r_overflow;
   assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - scoreboard bench for uart_rx_buffer (edge-read and strobe-read instances)
module tb_uart_rx_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_rx_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus1 ();
   uart_rx_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus2 ();

   uart_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 2), .RD_EDGE(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   uart_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 2), .RD_EDGE(0)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   int n_run  = 0;
   int n_fail = 0;
   int nv1    = 0;
   int nv2    = 0;
   int m1     = 0;
   int m2     = 0;
   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus1.out_valid) begin
         nv1++;
         if (q1.size() == 0) check("dut1_valid_without_expected", bus1.out_valid, 1'b0);
         else                check("dut1_data_out", bus1.data_out, q1.pop_front());
      end
      if (!rst && bus2.out_valid) begin
         nv2++;
         if (q2.size() == 0) check("dut2_valid_without_expected", bus2.out_valid, 1'b0);
         else                check("dut2_data_out", bus2.data_out, q2.pop_front());
      end
   end

   task automatic push1(input logic [DW-1:0] d);
      @(posedge clk); #1;
      bus1.rx_ready = 1'b1;
      bus1.data     = d;
      if (m1 < DEPTH) begin
         q1.push_back(d);
         m1++;
      end
      @(posedge clk); #1;
      bus1.rx_ready = 1'b0;
      @(negedge clk);
      check("dut1_count_after_push", bus1.count, m1);
   endtask

   task automatic pop1();
      @(posedge clk); #1;
      bus1.read = 1'b1;
      if (m1 > 0) m1--;
      @(posedge clk); #1;
      bus1.read = 1'b0;
      @(negedge clk);
      check("dut1_count_after_pop", bus1.count, m1);
   endtask

   task automatic both1(input logic [DW-1:0] d);
      bit pop_ok;
      bit push_ok;
      @(posedge clk); #1;
      bus1.rx_ready = 1'b1;
      bus1.read     = 1'b1;
      bus1.data     = d;
      pop_ok  = (m1 > 0);
      push_ok = (m1 < DEPTH) || pop_ok;
      if (push_ok) q1.push_back(d);
      m1 = m1 + int'(push_ok) - int'(pop_ok);
      @(posedge clk); #1;
      bus1.rx_ready = 1'b0;
      bus1.read     = 1'b0;
      @(negedge clk);
      check("dut1_count_after_both", bus1.count, m1);
   endtask

   task automatic push2(input logic [DW-1:0] d);
      @(posedge clk); #1;
      bus2.rx_ready = 1'b1;
      bus2.data     = d;
      if (m2 < DEPTH) begin
         q2.push_back(d);
         m2++;
      end
      @(posedge clk); #1;
      bus2.rx_ready = 1'b0;
      @(negedge clk);
      check("dut2_count_after_push", bus2.count, m2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      rst           = 1'b1;
      bus1.rx_ready = 1'b1;
      bus1.read     = 1'b1;
      bus1.data     = '0;
      bus1.clr_err  = 1'b0;
      bus2.rx_ready = 1'b1;
      bus2.read     = 1'b0;
      bus2.data     = '0;
      bus2.clr_err  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_count", bus1.count, 0);
      check("rst_empty", bus1.empty, 1);
      check("rst_full", bus1.full, 0);
      check("rst_almost_full", bus1.almost_full, 0);
      check("rst_out_valid", bus1.out_valid, 0);
      check("rst_data_out", bus1.data_out, 0);
      check("rst_overflow", bus1.overflow, 0);
      check("rst_underflow", bus1.underflow, 0);
      check("rst_dut2_empty", bus2.empty, 1);

      // levels held high across reset release must not count as edges
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("held_rx_ready_no_push", bus1.count, 0);
      check("held_read_no_underflow", bus1.underflow, 0);
      check("held_rx_ready_no_push_dut2", bus2.count, 0);
      @(posedge clk); #1;
      bus1.rx_ready = 1'b0;
      bus1.read     = 1'b0;
      bus2.rx_ready = 1'b0;

      push1(8'hA5);
      check("first_push_empty", bus1.empty, 0);
      pop1();
      check("first_pop_empty", bus1.empty, 1);

      // full lap of the pointers with in-order readback
      for (int i = 1; i <= DEPTH; i++) begin
         push1(8'(i));
         if (i == DEPTH - 3) check("almost_full_below_level", bus1.almost_full, 0);
         if (i == DEPTH - 2) check("almost_full_at_level", bus1.almost_full, 1);
      end
      check("fill_full", bus1.full, 1);
      base = nv1;
      repeat (DEPTH) pop1();
      @(posedge clk);
      @(negedge clk);
      check("drain_valid_pulses", nv1 - base, DEPTH);
      check("drain_empty", bus1.empty, 1);
      check("drain_almost_full", bus1.almost_full, 0);
      check("drain_no_underflow", bus1.underflow, 0);

      // overflow: dropped push, oldest word still at the head
      for (int i = 1; i <= DEPTH; i++) push1(8'(i));
      push1(8'h55);
      check("overflow_set", bus1.overflow, 1);
      check("overflow_count", bus1.count, DEPTH);
      pop1();
      check("overflow_sticky", bus1.overflow, 1);
      @(posedge clk); #1;
      bus1.clr_err = 1'b1;
      @(posedge clk); #1;
      bus1.clr_err = 1'b0;
      @(negedge clk);
      check("overflow_cleared", bus1.overflow, 0);

      // push and pop together on a full buffer
      push1(8'h11);
      check("refill_full", bus1.full, 1);
      both1(8'h66);
      check("both_full_no_overflow", bus1.overflow, 0);
      check("both_full_still_full", bus1.full, 1);

      // mid-operation reset with a flag set and a read edge on the reset edge
      push1(8'h77);
      check("overflow_before_reset", bus1.overflow, 1);
      repeat (9) pop1();
      check("count_before_reset", bus1.count, 7);
      @(posedge clk); #1;
      rst       = 1'b1;
      bus1.read = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_count", bus1.count, 0);
      check("midrst_empty", bus1.empty, 1);
      check("midrst_full", bus1.full, 0);
      check("midrst_out_valid", bus1.out_valid, 0);
      check("midrst_overflow", bus1.overflow, 0);
      check("midrst_underflow", bus1.underflow, 0);
      bus1.read = 1'b0;
      q1.delete();
      m1 = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      push1(8'hC3);
      pop1();

      // strobe-read instance: two pops then three ignored reads on empty
      push2(8'h3C);
      push2(8'h4D);
      base = nv2;
      @(posedge clk); #1;
      bus2.read = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus2.read = 1'b0;
      @(negedge clk);
      check("strobe_valid_pulses", nv2 - base, 2);
      check("strobe_underflow", bus2.underflow, 1);
      check("strobe_data_out_held", bus2.data_out, 8'h4D);
      check("strobe_empty", bus2.empty, 1);
      check("strobe_out_valid_low", bus2.out_valid, 0);

      @(posedge clk); #1;
      bus2.read    = 1'b1;
      bus2.clr_err = 1'b1;
      @(posedge clk); #1;
      bus2.read    = 1'b0;
      bus2.clr_err = 1'b0;
      @(negedge clk);
      check("clr_vs_new_error", bus2.underflow, 1);
      @(posedge clk); #1;
      bus2.clr_err = 1'b1;
      @(posedge clk); #1;
      bus2.clr_err = 1'b0;
      @(negedge clk);
      check("underflow_cleared", bus2.underflow, 0);

      @(posedge clk);
      @(negedge clk);
      check("sb1_drained", q1.size(), 0);
      check("sb2_drained", q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
